// File: rtl/alu_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, states,
// instruction field positions and status flag bit indices.
package alu_control_unit_pkg;

    localparam int IMM_W  = 8;
    localparam int FLAG_W = 5;

    localparam int OPC_LO = 12;
    localparam int RD_LO  = 10;
    localparam int RS_LO  = 8;
    localparam int IMM_LO = 0;

    localparam int FLAG_V = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_P = 0;

    typedef enum logic [3:0] {
        ALU_PASS = 4'h0,
        ALU_1    = 4'h1,
        ALU_2    = 4'h2,
        ALU_3    = 4'h3,
        ALU_4    = 4'h4,
        ALU_5    = 4'h5,
        ALU_6    = 4'h6,
        ALU_7    = 4'h7,
        OP_LDI   = 4'h8,
        OP_JMP   = 4'h9,
        OP_JZ    = 4'hA,
        OP_JN    = 4'hB,
        OP_JC    = 4'hC,
        OP_JV    = 4'hD,
        OP_JP    = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic logic isAluOp(opcode_t op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// Control-unit bus: program ROM port, ALU status flags, datapath selects
// and run/halt handshake.
interface alu_control_unit_if #(
    parameter int PCWIDTH    = 8,
    parameter int INSTRWIDTH = 16,
    parameter int SELECTION  = 3,
    parameter int REGADDR    = 2
);
    import alu_control_unit_pkg::*;

    logic                  sStart;
    logic [INSTRWIDTH-1:0] sInstr;
    logic                  sOverflow;
    logic                  sCarry;
    logic                  sNegative;
    logic                  sZero;
    logic                  sPar;
    logic [PCWIDTH-1:0]    sPc;
    logic [SELECTION-1:0]  sSelAlu;
    logic [REGADDR-1:0]    sRegSelA;
    logic [REGADDR-1:0]    sRegSelB;
    logic [REGADDR-1:0]    sRegDst;
    logic                  sRegWrite;
    logic                  sImmSel;
    logic [IMM_W-1:0]      sImm;
    logic [FLAG_W-1:0]     sFlags;
    logic                  sHalted;

    modport master (
        input  sStart, sInstr, sOverflow, sCarry, sNegative, sZero, sPar,
        output sPc, sSelAlu, sRegSelA, sRegSelB, sRegDst, sRegWrite,
               sImmSel, sImm, sFlags, sHalted
    );

    modport slave (
        output sStart, sInstr, sOverflow, sCarry, sNegative, sZero, sPar,
        input  sPc, sSelAlu, sRegSelA, sRegSelB, sRegDst, sRegWrite,
               sImmSel, sImm, sFlags, sHalted
    );

endinterface

// File: rtl/alu_control_unit_branch_resolve.sv
// Branch decision: taken when the opcode is JMP, or a conditional jump whose
// latched status flag is set.
module alu_branch_resolve
    import alu_control_unit_pkg::*;
(
    input  opcode_t           opcode,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = flags[FLAG_Z];
            OP_JN:   taken = flags[FLAG_N];
            OP_JC:   taken = flags[FLAG_C];
            OP_JV:   taken = flags[FLAG_V];
            OP_JP:   taken = flags[FLAG_P];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// Multicycle FETCH/DECODE/EXEC sequencer driving ALU and register-file
// selects from a synchronous program ROM, with a latched status register.
module alu_control_unit
    import alu_control_unit_pkg::*;
#(
    parameter int PCWIDTH    = 8,
    parameter int INSTRWIDTH = 16,
    parameter int SELECTION  = 3,
    parameter int REGADDR    = 2
) (
    input  logic             sClk,
    input  logic             sReset,
    alu_control_unit_if.master bus
);

    state_t                state;
    state_t                nextState;
    logic [PCWIDTH-1:0]    pc;
    logic [INSTRWIDTH-1:0] ir;
    logic [FLAG_W-1:0]     flags;
    logic [FLAG_W-1:0]     aluFlags;
    opcode_t               opcode;
    logic                  taken;
    logic                  inExec;

    assign opcode   = opcode_t'(ir[OPC_LO +: 4]);
    assign aluFlags = {bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero, bus.sPar};
    assign inExec   = (state == ST_EXEC);

    alu_branch_resolve uBranch (
        .opcode (opcode),
        .flags  (flags),
        .taken  (taken)
    );

    always_ff @(posedge sClk or posedge sReset) begin
        if (sReset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
        end else begin
            state <= nextState;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (bus.sStart) begin
                        pc    <= '0;
                        flags <= '0;
                    end
                end
                ST_DECODE: ir <= bus.sInstr;
                ST_EXEC: begin
                    if (isAluOp(opcode))
                        flags <= aluFlags;
                    // HALT leaves PC on the HALT instruction itself
                    if (opcode != OP_HALT)
                        pc <= taken ? PCWIDTH'(ir[IMM_LO +: IMM_W]) : pc + PCWIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (bus.sStart) nextState = ST_FETCH;
            ST_FETCH:  nextState = ST_DECODE;
            ST_DECODE: nextState = ST_EXEC;
            ST_EXEC:   nextState = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:   if (bus.sStart) nextState = ST_FETCH;
            default:   nextState = ST_IDLE;
        endcase
    end

    // Selects track the IR at all times so the datapath never sees a glitch;
    // only the write strobe and immediate mux are gated to EXEC.
    assign bus.sPc       = pc;
    assign bus.sSelAlu   = ir[OPC_LO +: SELECTION];
    assign bus.sRegSelA  = ir[RD_LO +: REGADDR];
    assign bus.sRegSelB  = ir[RS_LO +: REGADDR];
    assign bus.sRegDst   = ir[RD_LO +: REGADDR];
    assign bus.sImm      = ir[IMM_LO +: IMM_W];
    assign bus.sRegWrite = inExec && (isAluOp(opcode) || opcode == OP_LDI);
    assign bus.sImmSel   = inExec && (opcode == OP_LDI);
    assign bus.sFlags    = flags;
    // Halt is flagged as soon as the HALT instruction is executing.
    assign bus.sHalted   = (state == ST_HALT) || (inExec && opcode == OP_HALT);

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed scenarios plus random
// programs checked against an instruction-level reference model.
module tb_alu_control_unit;

    logic sClk = 1'b0;
    logic sReset;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] rom [256];

    alu_control_unit_if bus ();

    alu_control_unit dut (
        .sClk   (sClk),
        .sReset (sReset),
        .bus    (bus)
    );

    always #5 sClk = ~sClk;

    always @(posedge sClk) bus.sInstr <= rom[bus.sPc];

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic tick();
        @(negedge sClk);
    endtask

    task automatic tickN(input int n);
        repeat (n) @(negedge sClk);
    endtask

    task automatic setFlags(input logic [4:0] f);
        {bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero, bus.sPar} = f;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic doReset();
        sReset = 1'b1;
        bus.sStart = 1'b0;
        setFlags(5'b0);
        tick();
        sReset = 1'b0;
        clearRom();
        tick();
    endtask

    // Leaves the bench sampling cycle 1 (FETCH of PC 0)
    task automatic startProg();
        bus.sStart = 1'b1;
        tick();
        bus.sStart = 1'b0;
    endtask

    task automatic test_reset();
        sReset = 1'b1;
        bus.sStart = 1'b1;
        tick();
        checks++;
        if (bus.sPc !== 8'h00) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", bus.sPc, 8'h00);
        end
        checks++;
        if ({bus.sRegWrite, bus.sImmSel, bus.sHalted} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", {bus.sRegWrite, bus.sImmSel, bus.sHalted}, 3'b000);
        end
        checks++;
        if (bus.sFlags !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", bus.sFlags, 5'b0);
        end
        checks++;
        if ({bus.sSelAlu, bus.sRegSelA, bus.sRegSelB, bus.sRegDst, bus.sImm} !== 17'h0) begin
            errors++; $display("FAIL reset_selects: got %h expected %h",
                {bus.sSelAlu, bus.sRegSelA, bus.sRegSelB, bus.sRegDst, bus.sImm}, 17'h0);
        end
        bus.sStart = 1'b0;
        sReset = 1'b0;
        tickN(3);
        checks++;
        if ({bus.sPc, bus.sRegWrite} !== 9'h0) begin
            errors++; $display("FAIL idle_wait: got %h expected %h", {bus.sPc, bus.sRegWrite}, 9'h0);
        end
    endtask

    task automatic test_program();
        logic expW;
        doReset();
        rom[0] = 16'h8005;
        rom[1] = 16'h8403;
        rom[2] = 16'h2100;
        rom[3] = 16'hF000;
        startProg();
        for (int cyc = 1; cyc <= 13; cyc++) begin
            expW = (cyc == 3 || cyc == 6 || cyc == 9);
            checks++;
            if (bus.sRegWrite !== expW) begin
                errors++; $display("FAIL prog_write c%0d: got %b expected %b", cyc, bus.sRegWrite, expW);
            end
            if (cyc == 3) begin
                checks++;
                if ({bus.sImmSel, bus.sImm, bus.sRegDst} !== {1'b1, 8'h05, 2'd0}) begin
                    errors++; $display("FAIL prog_ldi: got %h expected %h",
                        {bus.sImmSel, bus.sImm, bus.sRegDst}, {1'b1, 8'h05, 2'd0});
                end
            end
            if (cyc == 9) begin
                checks++;
                if ({bus.sSelAlu, bus.sImmSel, bus.sRegDst, bus.sRegSelB} !== {3'b010, 1'b0, 2'd0, 2'd1}) begin
                    errors++; $display("FAIL prog_add: got %b expected %b",
                        {bus.sSelAlu, bus.sImmSel, bus.sRegDst, bus.sRegSelB}, {3'b010, 1'b0, 2'd0, 2'd1});
                end
            end
            if (cyc == 11 || cyc == 12 || cyc == 13) begin
                checks++;
                if ({bus.sHalted, bus.sPc} !== {(cyc != 11), 8'h03}) begin
                    errors++; $display("FAIL prog_halt c%0d: got %h expected %h",
                        cyc, {bus.sHalted, bus.sPc}, {(cyc != 11), 8'h03});
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_zero();
        logic [7:0] expPc;
        for (int z = 1; z >= 0; z--) begin
            doReset();
            rom[0]    = 16'h3000;
            rom[1]    = 16'hA040;
            rom[8'h40] = 16'hF000;
            setFlags({3'b000, z[0], 1'b0});
            startProg();
            tickN(3);
            checks++;
            if (bus.sFlags !== {3'b000, z[0], 1'b0}) begin
                errors++; $display("FAIL jz_flags z=%0d: got %b expected %b", z, bus.sFlags, {3'b000, z[0], 1'b0});
            end
            setFlags(5'b0);
            tickN(3);
            expPc = (z == 1) ? 8'h40 : 8'h02;
            checks++;
            if (bus.sPc !== expPc) begin
                errors++; $display("FAIL jz_target z=%0d: got %h expected %h", z, bus.sPc, expPc);
            end
        end
    endtask

    task automatic test_ldi_keeps_flags();
        doReset();
        rom[0]     = 16'h2100;
        rom[1]     = 16'h8811;
        rom[2]     = 16'hC020;
        rom[8'h20] = 16'hF000;
        setFlags(5'b01000);
        startProg();
        tickN(3);
        setFlags(5'b00000);
        tickN(2);
        checks++;
        if ({bus.sRegWrite, bus.sImmSel, bus.sImm, bus.sRegDst} !== {1'b1, 1'b1, 8'h11, 2'd2}) begin
            errors++; $display("FAIL ldi_write: got %h expected %h",
                {bus.sRegWrite, bus.sImmSel, bus.sImm, bus.sRegDst}, {1'b1, 1'b1, 8'h11, 2'd2});
        end
        tick();
        checks++;
        if (bus.sFlags !== 5'b01000) begin
            errors++; $display("FAIL ldi_flags: got %b expected %b", bus.sFlags, 5'b01000);
        end
        tickN(3);
        checks++;
        if (bus.sPc !== 8'h20) begin
            errors++; $display("FAIL jc_taken: got %h expected %h", bus.sPc, 8'h20);
        end
    endtask

    task automatic test_wrap();
        doReset();
        rom[0]     = 16'h90FF;
        rom[8'hFF] = 16'h0000;
        startProg();
        tickN(3);
        checks++;
        if (bus.sPc !== 8'hFF) begin
            errors++; $display("FAIL wrap_jmp: got %h expected %h", bus.sPc, 8'hFF);
        end
        tickN(3);
        checks++;
        if ({bus.sPc, bus.sFlags} !== {8'h00, 5'b0}) begin
            errors++; $display("FAIL wrap_pc: got %h expected %h", {bus.sPc, bus.sFlags}, {8'h00, 5'b0});
        end
    endtask

    task automatic test_reset_mid_exec();
        doReset();
        rom[0] = 16'h2100;
        rom[1] = 16'h2100;
        setFlags(5'b01000);
        startProg();
        tickN(5);
        checks++;
        if ({bus.sRegWrite, bus.sFlags, bus.sPc} !== {1'b1, 5'b01000, 8'h01}) begin
            errors++; $display("FAIL pre_abort: got %h expected %h",
                {bus.sRegWrite, bus.sFlags, bus.sPc}, {1'b1, 5'b01000, 8'h01});
        end
        sReset = 1'b1;
        #1;
        checks++;
        if ({bus.sRegWrite, bus.sFlags, bus.sPc, bus.sHalted} !== 15'h0) begin
            errors++; $display("FAIL async_abort: got %h expected %h",
                {bus.sRegWrite, bus.sFlags, bus.sPc, bus.sHalted}, 15'h0);
        end
        tick();
        sReset = 1'b0;
        tickN(4);
        checks++;
        if ({bus.sRegWrite, bus.sPc, bus.sFlags} !== 14'h0) begin
            errors++; $display("FAIL abort_idle: got %h expected %h", {bus.sRegWrite, bus.sPc, bus.sFlags}, 14'h0);
        end
    endtask

    task automatic test_halt_restart();
        doReset();
        rom[0] = 16'h8005;
        rom[1] = 16'h2100;
        rom[2] = 16'hF000;
        setFlags(5'b10101);
        startProg();
        tickN(9);
        checks++;
        if ({bus.sHalted, bus.sFlags, bus.sPc} !== {1'b1, 5'b10101, 8'h02}) begin
            errors++; $display("FAIL halt_state: got %h expected %h",
                {bus.sHalted, bus.sFlags, bus.sPc}, {1'b1, 5'b10101, 8'h02});
        end
        tickN(3);
        checks++;
        if ({bus.sHalted, bus.sRegWrite, bus.sPc} !== {1'b1, 1'b0, 8'h02}) begin
            errors++; $display("FAIL halt_hold: got %h expected %h",
                {bus.sHalted, bus.sRegWrite, bus.sPc}, {1'b1, 1'b0, 8'h02});
        end
        bus.sStart = 1'b1;
        tick();
        bus.sStart = 1'b0;
        checks++;
        if ({bus.sHalted, bus.sFlags, bus.sPc} !== 14'h0) begin
            errors++; $display("FAIL restart: got %h expected %h", {bus.sHalted, bus.sFlags, bus.sPc}, 14'h0);
        end
        tick();
        bus.sStart = 1'b1;
        tick();
        bus.sStart = 1'b0;
        checks++;
        if ({bus.sRegWrite, bus.sImm, bus.sPc} !== {1'b1, 8'h05, 8'h00}) begin
            errors++; $display("FAIL start_in_decode: got %h expected %h",
                {bus.sRegWrite, bus.sImm, bus.sPc}, {1'b1, 8'h05, 8'h00});
        end
        tick();
        checks++;
        if ({bus.sPc, bus.sHalted} !== {8'h01, 1'b0}) begin
            errors++; $display("FAIL after_restart: got %h expected %h", {bus.sPc, bus.sHalted}, {8'h01, 1'b0});
        end
    endtask

    // Instruction-level reference: each instruction is three cycles, only
    // ALU ops update the flags, branches test the flags held before the op.
    task automatic test_random();
        logic [7:0]  mPc;
        logic [4:0]  mFlags;
        logic [4:0]  f;
        logic [15:0] ins;
        logic [3:0]  op;
        logic        mTaken;
        logic [7:0]  expSel;
        int          condBit [5] = '{1, 2, 3, 4, 0};
        doReset();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        startProg();
        mPc = 8'h00;
        mFlags = 5'b0;
        for (int n = 0; n < 150; n++) begin
            checks++;
            if ({bus.sPc, bus.sFlags, bus.sRegWrite, bus.sImmSel, bus.sHalted} !== {mPc, mFlags, 3'b000}) begin
                errors++; $display("FAIL rnd_fetch n%0d: got %h expected %h", n,
                    {bus.sPc, bus.sFlags, bus.sRegWrite, bus.sImmSel, bus.sHalted}, {mPc, mFlags, 3'b000});
            end
            setFlags(5'($urandom)); bus.sStart = 1'($urandom);
            tick();
            checks++;
            if ({bus.sPc, bus.sRegWrite, bus.sImmSel} !== {mPc, 2'b00}) begin
                errors++; $display("FAIL rnd_decode n%0d: got %h expected %h", n,
                    {bus.sPc, bus.sRegWrite, bus.sImmSel}, {mPc, 2'b00});
            end
            setFlags(5'($urandom)); bus.sStart = 1'($urandom);
            tick();
            ins = rom[mPc];
            op  = ins[15:12];
            expSel = {1'b0, op[2:0], ins[11:10], ins[9:8]};
            checks++;
            if ({bus.sRegWrite, bus.sImmSel, bus.sHalted} !== {(op <= 4'h8), (op == 4'h8), (op == 4'hF)}) begin
                errors++; $display("FAIL rnd_exec_ctrl n%0d op%h: got %b expected %b", n, op,
                    {bus.sRegWrite, bus.sImmSel, bus.sHalted}, {(op <= 4'h8), (op == 4'h8), (op == 4'hF)});
            end
            checks++;
            if ({1'b0, bus.sSelAlu, bus.sRegSelA, bus.sRegSelB, bus.sRegDst, bus.sImm} !== {expSel, ins[11:10], ins[7:0]}) begin
                errors++; $display("FAIL rnd_exec_sel n%0d: got %h expected %h", n,
                    {1'b0, bus.sSelAlu, bus.sRegSelA, bus.sRegSelB, bus.sRegDst, bus.sImm},
                    {expSel, ins[11:10], ins[7:0]});
            end
            f = 5'($urandom);
            setFlags(f); bus.sStart = 1'($urandom);
            mTaken = (op == 4'h9) || (op >= 4'hA && op <= 4'hE && mFlags[condBit[op - 4'hA]]);
            if (op < 4'h8) mFlags = f;
            tick();
            if (op == 4'hF) begin
                checks++;
                if ({bus.sHalted, bus.sPc} !== {1'b1, mPc}) begin
                    errors++; $display("FAIL rnd_halt n%0d: got %h expected %h", n, {bus.sHalted, bus.sPc}, {1'b1, mPc});
                end
                bus.sStart = 1'b1;
                tick();
                bus.sStart = 1'b0;
                mPc = 8'h00;
                mFlags = 5'b0;
            end else begin
                mPc = mTaken ? ins[7:0] : 8'((int'(mPc) + 1) % 256);
            end
        end
        bus.sStart = 1'b0;
    endtask

    initial begin
        sReset = 1'b1;
        bus.sStart = 1'b0;
        setFlags(5'b0);
        clearRom();
        tick();
        test_reset();
        test_program();
        test_branch_zero();
        test_ldi_keeps_flags();
        test_wrap();
        test_reset_mid_exec();
        test_halt_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
